data_bus_arbiter: RTL and testbench

Two-master arbiter in front of the 16-bit data bus (memory plus memory-mapped devices selected by address bits [15:12]). It shares the bus between the pipeline's memory stage (master 0) and the debug/DMA port (master 1). Grants are round-robin. A bus cycle that the addressed device stretches with its wait request stays locked to one master until it completes. Single-cycle devices complete in the request cycle, so the pipeline sees no added latency.

---
 rtl/bus_pkg.sv | 14 +
 rtl/rr_pick2.sv | 16 +
 rtl/data_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_data_bus_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared definitions for the data bus arbiter: device codes, FSM state, abort data, master ids.
package bus_pkg;

    localparam logic [3:0]  DEV_MEM    = 4'h0;
    localparam logic [3:0]  DEV_FP     = 4'h1;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam logic [15:0] ABORT_DATA = 16'hDEAD;

    localparam int M_PIPE = 0;
    localparam int M_DMA  = 1;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin picker: lone requester wins, ties go to the master named by ptr.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win,
    output logic       any
);

    always_comb begin
        win = req;
        if (req == 2'b11) win = ptr ? 2'b10 : 2'b01;
    end

    assign any = |req;

endmodule

// File: rtl/data_bus_arbiter.sv
// Two-master round-robin data bus arbiter; stretched bus cycles stay locked to their owner.
// Optional stretch timeout/abort enabled by defining ARB_TIMEOUT_EN.
module data_bus_arbiter
    import bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 15
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [1:0]        ReqRead,
    input  logic [1:0]        ReqWrite,
    input  logic [ADDR_W-1:0] ReqAddr0,
    input  logic [ADDR_W-1:0] ReqAddr1,
    input  logic [DATA_W-1:0] ReqWdata0,
    input  logic [DATA_W-1:0] ReqWdata1,
    output logic [1:0]        ReqWait,
    output logic [1:0]        ReqErr,
    output logic [DATA_W-1:0] RdData,
    output logic [ADDR_W-1:0] BusAddr,
    output logic [DATA_W-1:0] BusWdata,
    output logic              BusRead,
    output logic              BusWrite,
    input  logic [DATA_W-1:0] BusRdata,
    input  logic              BusWaitreq,
    output logic [1:0]        Grant
);

    arb_state_t        state_q, state_d;
    logic [1:0]        req, win, own_oh, done_oh;
    logic              any, win_idx, abort;
    logic              rr_ptr_q, own_q, rd_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign req     = ReqRead | ReqWrite;
    assign win_idx = win[M_DMA];
    assign own_oh  = {own_q, ~own_q};

    rr_pick2 u_pick (
        .req (req),
        .ptr (rr_ptr_q),
        .win (win),
        .any (any)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    // cnt_q holds the ordinal of the current BUSY cycle (1 on the first one)
    logic [CW-1:0] cnt_q;

    assign abort = (state_q == BUSY) && BusWaitreq && (cnt_q == CW'(TIMEOUT));

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset)                                    cnt_q <= '0;
        else if (state_q == IDLE && state_d == BUSY)  cnt_q <= CW'(1);
        else if (state_q == BUSY)                     cnt_q <= cnt_q + 1'b1;
    end
`else
    logic [31:0] unused_timeout;
    assign unused_timeout = 32'(TIMEOUT);
    assign abort          = 1'b0;
`endif

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any && BusWaitreq) state_d = BUSY;
            BUSY:    if (!BusWaitreq || abort) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs; Reset gates everything so strobes drop asynchronously
    always_comb begin
        BusAddr  = '0;
        BusWdata = '0;
        BusRead  = 1'b0;
        BusWrite = 1'b0;
        Grant    = 2'b00;
        ReqErr   = 2'b00;
        done_oh  = 2'b00;
        RdData   = BusRdata;
        if (Reset) begin
            done_oh = 2'b00;
        end else if (state_q == IDLE) begin
            if (any) begin
                Grant    = win;
                BusAddr  = win_idx ? ReqAddr1 : ReqAddr0;
                BusWdata = win_idx ? ReqWdata1 : ReqWdata0;
                BusRead  = ReqRead[win_idx];
                BusWrite = ~ReqRead[win_idx] & ReqWrite[win_idx];
                if (!BusWaitreq) done_oh = win;
            end
        end else begin
            Grant    = own_oh;
            BusAddr  = addr_q;
            BusWdata = wdata_q;
            if (abort) begin
                RdData  = DATA_W'(ABORT_DATA);
                ReqErr  = own_oh;
                done_oh = own_oh;
            end else begin
                BusRead  = rd_q;
                BusWrite = ~rd_q;
                if (!BusWaitreq) done_oh = own_oh;
            end
        end
        ReqWait = req & ~done_oh;
    end

    // Latch the winning request on stretch; advance the pointer past whoever completed
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            rr_ptr_q <= 1'b0;
            own_q    <= 1'b0;
            rd_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
        end else if (state_q == IDLE && any) begin
            if (BusWaitreq) begin
                own_q   <= win_idx;
                rd_q    <= ReqRead[win_idx];
                addr_q  <= BusAddr;
                wdata_q <= BusWdata;
            end else begin
                rr_ptr_q <= ~win_idx;
            end
        end else if (state_q == BUSY && state_d == IDLE) begin
            rr_ptr_q <= ~own_q;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter: directed vector table, randomized run
// against a behavioural model, and (with ARB_TIMEOUT_EN) a stretch-timeout sequence.
module tb_data_bus_arbiter;

    typedef struct packed {
        logic [1:0]  grant;
        logic [1:0]  wt;
        logic [1:0]  err;
        logic [15:0] rdata;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        rd;
        logic        wr;
    } out_t;

    typedef struct {
        logic        rst;
        logic [1:0]  rr, rw;
        logic [15:0] a0, a1, d0, d1;
        logic        wq;
        logic [15:0] brd;
        out_t        exp;
    } vec_t;

    localparam int TMO = 15;

    logic        Clock = 1'b0;
    logic        rst, wq;
    logic [1:0]  rr, rw;
    logic [15:0] a0, a1, d0, d1, brd;

    logic [1:0]  ReqWait, ReqErr, Grant;
    logic [15:0] RdData, BusAddr, BusWdata;
    logic        BusRead, BusWrite;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    data_bus_arbiter dut (
        .Clock      (Clock),
        .Reset      (rst),
        .ReqRead    (rr),
        .ReqWrite   (rw),
        .ReqAddr0   (a0),
        .ReqAddr1   (a1),
        .ReqWdata0  (d0),
        .ReqWdata1  (d1),
        .ReqWait    (ReqWait),
        .ReqErr     (ReqErr),
        .RdData     (RdData),
        .BusAddr    (BusAddr),
        .BusWdata   (BusWdata),
        .BusRead    (BusRead),
        .BusWrite   (BusWrite),
        .BusRdata   (brd),
        .BusWaitreq (wq),
        .Grant      (Grant)
    );

    // Reference model: one pending locked transfer or none, plus the tie-break pointer
    bit          m_busy, m_own, m_rd, m_ptr;
    logic [15:0] m_addr, m_wdata;
    int          m_cnt;

    function automatic int pick();
        logic [1:0] r;
        r = rr | rw;
        if (r == 2'b00) return -1;
        if (r == 2'b11) return m_ptr ? 1 : 0;
        return r[1] ? 1 : 0;
    endfunction

    function automatic bit timed_out();
`ifdef ARB_TIMEOUT_EN
        return m_busy && wq && (m_cnt == TMO);
`else
        return 1'b0;
`endif
    endfunction

    function automatic out_t model_out();
        out_t e;
        int   w;
        e       = '0;
        w       = pick();
        e.rdata = brd;
        e.wt    = rr | rw;
        if (rst) return e;
        if (!m_busy) begin
            if (w >= 0) begin
                e.grant[w] = 1'b1;
                e.addr     = (w == 1) ? a1 : a0;
                e.wdata    = (w == 1) ? d1 : d0;
                e.rd       = rr[w];
                e.wr       = !rr[w] && rw[w];
                if (!wq) e.wt[w] = 1'b0;
            end
        end else begin
            e.grant[m_own] = 1'b1;
            e.addr         = m_addr;
            e.wdata        = m_wdata;
            if (timed_out()) begin
                e.err[m_own] = 1'b1;
                e.rdata      = 16'hDEAD;
                e.wt[m_own]  = 1'b0;
            end else begin
                e.rd = m_rd;
                e.wr = !m_rd;
                if (!wq) e.wt[m_own] = 1'b0;
            end
        end
        return e;
    endfunction

    task automatic model_clock();
        int w;
        w = pick();
        if (rst) begin
            m_busy = 0; m_own = 0; m_rd = 0; m_ptr = 0;
            m_addr = '0; m_wdata = '0; m_cnt = 0;
        end else if (!m_busy) begin
            if (w >= 0) begin
                if (wq) begin
                    m_busy  = 1;
                    m_own   = (w == 1);
                    m_addr  = (w == 1) ? a1 : a0;
                    m_wdata = (w == 1) ? d1 : d0;
                    m_rd    = rr[w];
                    m_cnt   = 1;
                end else begin
                    m_ptr = (w == 0);
                end
            end
        end else if (!wq || timed_out()) begin
            m_busy = 0;
            m_ptr  = !m_own;
        end else begin
            m_cnt++;
        end
    endtask

    task automatic check(input string name, input out_t e);
        out_t a;
        a = {Grant, ReqWait, ReqErr, RdData, BusAddr, BusWdata, BusRead, BusWrite};
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got grant=%b wait=%b err=%b rdata=%h addr=%h wdata=%h rd=%b wr=%b; want grant=%b wait=%b err=%b rdata=%h addr=%h wdata=%h rd=%b wr=%b",
                     name, a.grant, a.wt, a.err, a.rdata, a.addr, a.wdata, a.rd, a.wr,
                     e.grant, e.wt, e.err, e.rdata, e.addr, e.wdata, e.rd, e.wr);
        end
    endtask

    task automatic tick();
        model_clock();
        @(posedge Clock);
        #1;
    endtask

    function automatic vec_t mk(input logic r, input logic [1:0] irr, irw,
                                input logic [15:0] ia0, ia1, id0, id1, input logic iwq,
                                input logic [15:0] ibrd, input logic [1:0] eg, ew,
                                input logic [15:0] ea, ed, input logic erd, ewr);
        vec_t v;
        v.rst = r; v.rr = irr; v.rw = irw; v.a0 = ia0; v.a1 = ia1;
        v.d0 = id0; v.d1 = id1; v.wq = iwq; v.brd = ibrd;
        v.exp = '{grant: eg, wt: ew, err: 2'b00, rdata: ibrd,
                  addr: ea, wdata: ed, rd: erd, wr: ewr};
        return v;
    endfunction

`ifdef ARB_TIMEOUT_EN
    task automatic timeout_seq();
        out_t e;
        rst = 1; rr = 0; rw = 0; wq = 0; brd = 16'h4321;
        a0 = 16'h0040; a1 = 16'h0050; d0 = '0; d1 = '0;
        #4; tick();
        rst = 0; rr = 2'b11; wq = 1;
        for (int k = 0; k <= TMO; k++) begin
            #4;
            e = '0; e.grant = 2'b01; e.addr = 16'h0040; e.wt = 2'b11; e.rdata = brd; e.rd = 1;
            if (k == TMO) begin
                e.rd = 0; e.err = 2'b01; e.rdata = 16'hDEAD; e.wt = 2'b10;
            end
            check($sformatf("timeout_%0d", k), e);
            tick();
        end
        wq = 0; #4;
        e = '0; e.grant = 2'b10; e.addr = 16'h0050; e.rd = 1; e.rdata = brd; e.wt = 2'b01;
        check("timeout_next_grant", e);
        tick();
    endtask
`endif

    vec_t tab[$];

    initial begin
        rst = 1; rr = 0; rw = 0; wq = 0;
        a0 = '0; a1 = '0; d0 = '0; d1 = '0; brd = '0;
        m_busy = 0; m_own = 0; m_rd = 0; m_ptr = 0; m_addr = '0; m_wdata = '0; m_cnt = 0;

        // reset with both requesting, then master 0 wins first
        tab.push_back(mk(1, 2'b11, 2'b00, 16'h0010, 16'h0020, 0, 0, 0, 16'h1111, 2'b00, 2'b11, 16'h0000, 16'h0000, 0, 0));
        tab.push_back(mk(0, 2'b11, 2'b00, 16'h0010, 16'h0020, 0, 0, 0, 16'h1111, 2'b01, 2'b10, 16'h0010, 16'h0000, 1, 0));
        // single-cycle reads
        tab.push_back(mk(0, 2'b01, 2'b00, 16'h0010, 16'h0020, 0, 0, 0, 16'h1234, 2'b01, 2'b00, 16'h0010, 16'h0000, 1, 0));
        tab.push_back(mk(0, 2'b10, 2'b00, 16'h0010, 16'h0020, 0, 0, 0, 16'h5678, 2'b10, 2'b00, 16'h0020, 16'h0000, 1, 0));
        tab.push_back(mk(0, 2'b00, 2'b00, 16'h0010, 16'h0020, 0, 0, 0, 16'h0000, 2'b00, 2'b00, 16'h0000, 16'h0000, 0, 0));
        // contention: alternating writes
        for (int i = 0; i < 4; i++)
            tab.push_back(mk(0, 2'b00, 2'b11, 16'h0004, 16'h0008, 16'h00A0, 16'h00B0, 0, 16'h0000,
                             (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 2'b10 : 2'b01,
                             (i % 2 == 0) ? 16'h0004 : 16'h0008, (i % 2 == 0) ? 16'h00A0 : 16'h00B0, 0, 1));
        // stretched write by master 1; it changes inputs mid-cycle, master 0 waits
        tab.push_back(mk(0, 2'b00, 2'b10, 16'h0004, 16'h1002, 16'h00A0, 16'hBEEF, 1, 16'h0000, 2'b10, 2'b10, 16'h1002, 16'hBEEF, 0, 1));
        tab.push_back(mk(0, 2'b10, 2'b01, 16'h0004, 16'h2222, 16'h00A0, 16'h3333, 1, 16'h0000, 2'b10, 2'b11, 16'h1002, 16'hBEEF, 0, 1));
        tab.push_back(mk(0, 2'b10, 2'b01, 16'h0004, 16'h2222, 16'h00A0, 16'h3333, 1, 16'h0000, 2'b10, 2'b11, 16'h1002, 16'hBEEF, 0, 1));
        tab.push_back(mk(0, 2'b10, 2'b01, 16'h0004, 16'h2222, 16'h00A0, 16'h3333, 0, 16'h0000, 2'b10, 2'b01, 16'h1002, 16'hBEEF, 0, 1));
        tab.push_back(mk(0, 2'b00, 2'b01, 16'h0004, 16'h2222, 16'h00A0, 16'h3333, 0, 16'h0000, 2'b01, 2'b00, 16'h0004, 16'h00A0, 0, 1));
        // reset in the middle of a stretched read
        tab.push_back(mk(0, 2'b01, 2'b00, 16'h0030, 16'h0020, 0, 0, 1, 16'h0000, 2'b01, 2'b01, 16'h0030, 16'h0000, 1, 0));
        tab.push_back(mk(0, 2'b01, 2'b00, 16'h0030, 16'h0020, 0, 0, 1, 16'h0000, 2'b01, 2'b01, 16'h0030, 16'h0000, 1, 0));
        tab.push_back(mk(1, 2'b01, 2'b00, 16'h0030, 16'h0020, 0, 0, 1, 16'h0000, 2'b00, 2'b01, 16'h0000, 16'h0000, 0, 0));
        tab.push_back(mk(0, 2'b11, 2'b00, 16'h0030, 16'h0020, 0, 0, 0, 16'h0000, 2'b01, 2'b10, 16'h0030, 16'h0000, 1, 0));

        @(posedge Clock);
        #1;
        for (int i = 0; i < tab.size(); i++) begin
            rst = tab[i].rst; rr = tab[i].rr; rw = tab[i].rw;
            a0 = tab[i].a0; a1 = tab[i].a1; d0 = tab[i].d0; d1 = tab[i].d1;
            wq = tab[i].wq; brd = tab[i].brd;
            #4;
            check($sformatf("vec_%0d", i), tab[i].exp);
            tick();
        end

        for (int n = 0; n < 1500; n++) begin
            int v0, v1;
            rst = (n == 0) || ($urandom_range(0, 199) == 0);
            v0 = $urandom_range(0, 7);
            v1 = $urandom_range(0, 7);
            rr  = {(v1 == 3 || v1 == 4 || v1 == 7), (v0 == 3 || v0 == 4 || v0 == 7)};
            rw  = {(v1 >= 5), (v0 >= 5)};
            a0  = 16'($urandom); a1 = 16'($urandom);
            d0  = 16'($urandom); d1 = 16'($urandom);
            brd = 16'($urandom);
            wq  = ($urandom_range(0, 2) == 0);
            #4;
            check($sformatf("rand_%0d", n), model_out());
            tick();
        end

`ifdef ARB_TIMEOUT_EN
        timeout_seq();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
